round_sequencer: RTL
====================

# round_sequencer

Control FSM that sequences the iterative datapath: the round-state registers, which are enable-gated flops with a 6-bit round-count enable, plus their round-function logic. It accepts a start request, issues a one-cycle load of the initial state, then drives the round counter and round enable for exactly `ROUNDS` cycles. It then presents a valid result and holds it until the consumer acknowledges. It sits between the top-level I/O handshake and the datapath and is the only writer of the datapath's load and enable strobes.

## Interface
- `ROUNDS`, default 64: number of round iterations; legal range 1..64.
- `CW`, default 6: round-counter width; must satisfy 2^CW ≥ `ROUNDS`.
- `clk` input, 1 bit: sole clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-low reset (0 = reset), sampled on the `clk` rising edge.
- `start` input, 1 bit: request a new operation; sampled only in IDLE.
- `ack` input, 1 bit: consumer has taken the result; sampled only in DONE.
- `abort` input, 1 bit: cancel the operation in progress. Present only when `ROUND_SEQ_ABORT_EN` is defined.
- `load` output, 1 bit: datapath loads the initial state this cycle.
- `round_en` output, 1 bit: datapath advances one round this cycle.
- `count` output, `CW` bits: index of the round being computed this cycle.
- `busy` output, 1 bit: high in LOAD and RUN.
- `valid` output, 1 bit: result registers hold the final value.
- `done` output, 1 bit: one-cycle pulse on entry to DONE.

## Operation
- States: IDLE, LOAD, RUN, DONE. All outputs are registered or decoded from the state register only; there is no combinational input-to-output path.
- Reset (`reset` = 0): state goes to IDLE and `count` = 0. `load`, `round_en`, `busy`, `valid` and `done` are all 0.
- IDLE: `start` = 1 moves to LOAD. Otherwise stay in IDLE. `ack` is ignored.
- LOAD: lasts exactly one cycle. `load` = 1, `busy` = 1, `count` = 0. Always moves to RUN.
- RUN:
  - `round_en` = 1 and `busy` = 1 on every cycle.
  - `count` increments by 1 each cycle, from 0 up to `ROUNDS`-1.
  - When `count` = `ROUNDS`-1, `count` returns to 0 and the state moves to DONE.
  - `count` never exceeds `ROUNDS`-1. With `ROUNDS` = 64 the terminal value is 63 and the wrap to 0 is explicit, not an overflow.
- DONE:
  - `valid` = 1. `done` = 1 only on the first DONE cycle.
  - `round_en` = 0 and `load` = 0, so the result registers are frozen.
  - `ack` = 1 moves to IDLE. Without `ack`, stay in DONE indefinitely.
- `start` held high through DONE does not retrigger. A new operation needs `start` = 1 sampled in IDLE, which is at least one cycle after `ack`.
- `start` and `ack` both high in DONE: `ack` wins, the next state is IDLE, and `start` is re-evaluated on the following cycle.
- `start` asserted in LOAD or RUN is ignored.
- Reset mid-operation: IDLE on the next edge, and any partial result is discarded. `valid` must not assert.

## Timing
- `start` sampled high at edge E0 gives:
  - `load` = 1 in cycle E0..E1.
  - `round_en` = 1 for cycles E1..E(`ROUNDS`+1), with `count` = 0..`ROUNDS`-1.
  - `valid` and `done` high from E(`ROUNDS`+1).
- Latency from start to valid is `ROUNDS`+1 cycles; with the default this is 65 cycles.
- Minimum start-to-start period is `ROUNDS`+3 cycles, assuming `ack` is returned in the first DONE cycle.
- `busy` and `valid` are never high in the same cycle.
- `load` and `round_en` are never high in the same cycle.

## Configuration
- `ROUND_SEQ_ABORT_EN` defined:
  - The `abort` port exists.
  - `abort` = 1 in LOAD or RUN moves to IDLE on the next edge. `count` is cleared and `valid` and `done` are not asserted.
  - `abort` in IDLE or DONE is ignored.
  - `abort` and `reset` active together give reset behaviour, which is identical.
- `ROUND_SEQ_ABORT_EN` undefined: no `abort` port, and LOAD/RUN always run to completion.

## Test plan
- Reset, then idle 5 cycles → all outputs 0 and `count` = 0.
- `ROUNDS` = 64, pulse `start` → `load` for 1 cycle; `round_en` for 64 cycles with `count` stepping 0..63; `valid` and `done` at cycle 65. `ack` one cycle later → IDLE with `valid` = 0.
- `ROUNDS` = 1 → one RUN cycle with `count` = 0; `valid` 2 cycles after the `start` edge.
- Hold `ack` low for 10 DONE cycles with `start` held high → `valid` stays 1, `done` pulses once, no restart. Then `ack` and `start` together → IDLE, and a new LOAD one cycle later.
- Reset asserted at RUN `count` = 30 → next cycle IDLE, `count` = 0, `valid` never asserted.
- With `ROUND_SEQ_ABORT_EN`: `abort` at `count` = 10 → IDLE next cycle, no `done`. `abort` asserted in DONE → no effect.

Source files
------------

// File: rtl/round_sequencer.sv
// Control FSM for the iterative round datapath: start -> one-cycle LOAD -> ROUNDS cycles of RUN -> DONE until ack.
// Optional cancel input enabled by defining ROUND_SEQ_ABORT_EN.
module round_sequencer #(
    parameter int unsigned ROUNDS = 64,
    parameter int unsigned CW     = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ack,
`ifdef ROUND_SEQ_ABORT_EN
    input  logic          abort,
`endif
    output logic          load,
    output logic          round_en,
    output logic [CW-1:0] count,
    output logic          busy,
    output logic          valid,
    output logic          done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_next;
    logic          done_q;
    logic          done_next;
    logic          abort_req;

`ifdef ROUND_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_next;
            count_q <= count_next;
            done_q  <= done_next;
        end
    end

    // The terminal round wraps count to zero explicitly so CW may equal log2(ROUNDS).
    always_comb begin
        state_next = state;
        count_next = count_q;
        done_next  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                count_next = '0;
                if (start) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_next = '0;
                state_next = abort_req ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (abort_req) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end else if (count_q == LAST) begin
                    state_next = ST_DONE;
                    count_next = '0;
                    done_next  = 1'b1;
                end else begin
                    count_next = count_q + CW'(1);
                end
            end
            ST_DONE: begin
                count_next = '0;
                if (ack) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                count_next = '0;
            end
        endcase
    end

    always_comb begin
        load     = (state == ST_LOAD);
        round_en = (state == ST_RUN);
        busy     = (state == ST_LOAD) || (state == ST_RUN);
        valid    = (state == ST_DONE);
        done     = done_q;
        count    = count_q;
    end

endmodule
